counter_checker: RTL
====================

// Module: counter_checker
// PURPOSE
//  Self-checking monitor for the free-running up-counter (clk/rst/count).
//  Consumes the counter's count output, predicts its value every cycle,
//  counts mismatches, and issues a PASS/FAIL verdict after CHECK_CYCLES
//  comparisons. It is synthesizable, so it can be used in simulation or in
//  an FPGA bring-up build beside the counter, sharing the counter's clk/rst.
// PARAMETERS
//  WIDTH         8    width of observed count, in bits
//  RESET_VAL     0    value the counter holds in the first cycle after reset
//  CHECK_CYCLES  100  number of comparisons before the verdict (>=1)
//  ERR_W         8    width of the error counter, which saturates
// PORTS
//  clk          in   1          clock, shared with the counter
//  rst          in   1          synchronous reset, active-high, shared with the counter
//  count        in   WIDTH      observed counter output
//  done         out  1          verdict valid; sticky until rst
//  pass         out  1          done & zero mismatches; sticky
//  fail         out  1          done & >=1 mismatch; sticky
//  err_cnt      out  ERR_W      mismatches seen so far, saturating at all-ones
//  first_exp    out  WIDTH      expected value at the first mismatch
//  first_got    out  WIDTH      observed value at the first mismatch
//  cycle_cnt    out  clog2(CHECK_CYCLES+1)  comparisons performed
// BEHAVIOUR
//  - One clock, clk. Reset is synchronous and active-high on rst.
//    All outputs are registered.
//  - Reset values: state=CHECK, exp=RESET_VAL, done/pass/fail=0, err_cnt=0,
//    first_exp=first_got=0, cycle_cnt=0, internal first_seen=0.
//  - State machine:
//    - CHECK -> DONE when the CHECK_CYCLES-th comparison is made.
//    - DONE is held until rst.
//  - CHECK, every cycle with rst=0, compares count against exp:
//    - match: exp <= exp+1 mod 2^WIDTH, so (2^WIDTH-1) wraps to 0.
//    - mismatch:
//      - err_cnt increments; at all-ones it stays all-ones.
//      - If first_seen=0: capture first_exp<=exp, first_got<=count, and set
//        first_seen. Later mismatches do not overwrite the capture.
//      - Resync: exp <= count+1 mod 2^WIDTH. A single glitch therefore costs
//        at most 2 errors, not a cascade.
//    - cycle_cnt increments once per comparison.
//  - Verdict: the comparison with cycle_cnt==CHECK_CYCLES-1 is the last one,
//    and it is included in err_cnt. On the next edge, in the same cycle as
//    the state enters DONE:
//    - done=1
//    - pass = (updated err_cnt==0)
//    - fail = ~pass
//  - DONE: no comparisons. All outputs frozen. count is ignored.
//  - rst at any time, including mid-CHECK or in DONE: returns to reset
//    values on that edge. Checking restarts on the first cycle with rst=0,
//    expecting RESET_VAL.
//  - pass and fail are never both 1. pass|fail == done.
//  - No X-propagation guard: an X on count counts as a mismatch (sim only).
// TESTING
//  1. Ideal counter, WIDTH=8, CHECK_CYCLES=100: count 0,1,..,99 -> done on
//     cycle 101 after rst falls, pass=1, err_cnt=0, cycle_cnt=100.
//  2. Wrap, WIDTH=4, CHECK_CYCLES=40: count 0..15,0..15,0..7 -> pass=1,
//     err_cnt=0.
//  3. Single glitch: count 5 replaced by 9, sequence continuing 6,7 ->
//     err_cnt=2, first_exp=5, first_got=9, fail=1 at done.
//  4. Stuck counter: count held at 0 throughout -> first_exp=1, first_got=0,
//     err_cnt=CHECK_CYCLES-1=99, fail=1.
//  5. Saturation, ERR_W=3, CHECK_CYCLES=20, count random/non-incrementing ->
//     err_cnt stays at 7 and never wraps to 0, fail=1.
//  6. rst pulsed for 1 cycle at comparison 50, then ideal counter restarts
//     from 0 -> all outputs cleared that edge; done 100 comparisons later,
//     pass=1. rst while done=1 -> done/pass drop to 0 next edge.

Source files
------------

// File: rtl/counter_checker.sv
// -----------------------------------------------------------------------------
// counter_checker
//
// Synthesizable monitor for a free-running up-counter. Every cycle it predicts
// the counter value and compares it with the observed count. It counts the
// mismatches in a saturating counter and records the first one. After
// CHECK_CYCLES comparisons it issues a sticky PASS/FAIL verdict.
// This module shares clk and rst with the counter it watches.
//
// Ports
//   clk        in   1        clock, shared with the counter
//   rst        in   1        synchronous reset, active-high
//   count      in   WIDTH    observed counter output
//   done       out  1        verdict valid, sticky until rst
//   pass       out  1        done and no mismatch seen
//   fail       out  1        done and at least one mismatch seen
//   err_cnt    out  ERR_W    mismatch count, saturates at all-ones
//   first_exp  out  WIDTH    predicted value at the first mismatch
//   first_got  out  WIDTH    observed value at the first mismatch
//   cycle_cnt  out  CNT_W    comparisons performed so far
// -----------------------------------------------------------------------------
module counter_checker #(
   parameter int WIDTH        = 8,
   parameter int RESET_VAL    = 0,
   parameter int CHECK_CYCLES = 100,
   parameter int ERR_W        = 8,
   localparam int CNT_W       = $clog2(CHECK_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] count,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic [ERR_W-1:0] err_cnt,
   output logic [WIDTH-1:0] first_exp,
   output logic [WIDTH-1:0] first_got,
   output logic [CNT_W-1:0] cycle_cnt
);

   typedef enum logic {
      ST_CHECK = 1'b0,
      ST_DONE  = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] EXP_INIT   = WIDTH'(RESET_VAL);
   localparam logic [ERR_W-1:0] ERR_MAX    = '1;
   localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(CHECK_CYCLES - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_exp;
   logic             r_done;
   logic             r_pass;
   logic             r_fail;
   logic [ERR_W-1:0] r_err;
   logic [WIDTH-1:0] r_first_exp;
   logic [WIDTH-1:0] r_first_got;
   logic             r_first_seen;
   logic [CNT_W-1:0] r_cycle;

   state_t           w_state_next;
   logic [WIDTH-1:0] w_exp_next;
   logic             w_done_next;
   logic             w_pass_next;
   logic             w_fail_next;
   logic [ERR_W-1:0] w_err_next;
   logic [WIDTH-1:0] w_first_exp_next;
   logic [WIDTH-1:0] w_first_got_next;
   logic             w_first_seen_next;
   logic [CNT_W-1:0] w_cycle_next;
   logic             w_match;

   assign w_match = (count == r_exp);

   always_comb begin
      w_state_next      = r_state;
      w_exp_next        = r_exp;
      w_done_next       = r_done;
      w_pass_next       = r_pass;
      w_fail_next       = r_fail;
      w_err_next        = r_err;
      w_first_exp_next  = r_first_exp;
      w_first_got_next  = r_first_got;
      w_first_seen_next = r_first_seen;
      w_cycle_next      = r_cycle;

      case (r_state)
         ST_CHECK: begin
            w_cycle_next = r_cycle + CNT_W'(1);
            // The mismatch path is the else branch. An unknown count in
            // simulation therefore counts as an error and does not pass silently.
            if (w_match) begin
               w_exp_next = r_exp + WIDTH'(1);
            end else begin
               if (r_err != ERR_MAX) begin
                  w_err_next = r_err + ERR_W'(1);
               end
               if (!r_first_seen) begin
                  w_first_exp_next  = r_exp;
                  w_first_got_next  = count;
                  w_first_seen_next = 1'b1;
               end
               // Resynchronise on the observed value. A single glitch then
               // costs at most two errors instead of an error on every later cycle.
               w_exp_next = count + WIDTH'(1);
            end
            // The verdict includes the error from this last comparison.
            if (r_cycle == LAST_CYCLE) begin
               w_state_next = ST_DONE;
               w_done_next  = 1'b1;
               w_pass_next  = (w_err_next == '0);
               w_fail_next  = (w_err_next != '0);
            end
         end
         ST_DONE: begin
            // Verdict frozen until reset; count ignored.
         end
         default: begin
            w_state_next = ST_CHECK;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_CHECK;
         r_exp        <= EXP_INIT;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_fail       <= 1'b0;
         r_err        <= '0;
         r_first_exp  <= '0;
         r_first_got  <= '0;
         r_first_seen <= 1'b0;
         r_cycle      <= '0;
      end else begin
         r_state      <= w_state_next;
         r_exp        <= w_exp_next;
         r_done       <= w_done_next;
         r_pass       <= w_pass_next;
         r_fail       <= w_fail_next;
         r_err        <= w_err_next;
         r_first_exp  <= w_first_exp_next;
         r_first_got  <= w_first_got_next;
         r_first_seen <= w_first_seen_next;
         r_cycle      <= w_cycle_next;
      end
   end

   assign done      = r_done;
   assign pass      = r_pass;
   assign fail      = r_fail;
   assign err_cnt   = r_err;
   assign first_exp = r_first_exp;
   assign first_got = r_first_got;
   assign cycle_cnt = r_cycle;

endmodule
